// File: rtl/debug_cmd_sequencer_if.sv
// Command/response signal bundle between UART RX/TX, the debug decoder and
// debug_cmd_sequencer. master = sequencer side, slave = surrounding blocks.
interface debug_cmd_sequencer_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  dec_code;
  logic [31:0] dec_result;
  logic [1:0]  dec_size;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        busy;
  logic        overrun;

  modport master (
    input  rx_data, rx_valid, dec_result, dec_size, tx_busy,
    output dec_code, tx_data, tx_start, busy, overrun
  );

  modport slave (
    output rx_data, rx_valid, dec_result, dec_size, tx_busy,
    input  dec_code, tx_data, tx_start, busy, overrun
  );
endinterface

// File: rtl/debug_cmd_sequencer.sv
// Debugger command sequencer: latches a UART command byte, captures the decoder
// response and streams it MSB-first to the UART TX. Optional echo: DBG_ECHO_EN.
module debug_cmd_sequencer (
  input logic                   clk,
  input logic                   reset,
  debug_cmd_sequencer_if.master bus
);

`ifdef DBG_ECHO_EN
  localparam int SH_W  = 40;
  localparam int CNT_W = 3;
`else
  localparam int SH_W  = 32;
  localparam int CNT_W = 2;
`endif

  typedef enum logic [1:0] {IDLE, DECODE, LOAD, HOLD} state_t;

  state_t            state, state_nxt;
  logic [SH_W-1:0]   shreg, shreg_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [7:0]        code, code_nxt;
  logic              busy_q;
  logic              overrun_q, overrun_nxt;
  logic [1:0]        pad_bytes;
  logic [31:0]       aligned;

  // Left-justify the size+1 valid low bytes of result so shreg[top] is sent first.
  assign pad_bytes = 2'd3 - bus.dec_size;
  assign aligned   = bus.dec_result << {pad_bytes, 3'b000};

  always_comb begin
    state_nxt    = state;
    shreg_nxt    = shreg;
    cnt_nxt      = cnt;
    code_nxt     = code;
    overrun_nxt  = overrun_q;
    bus.tx_start = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          code_nxt  = bus.rx_data;
          state_nxt = DECODE;
        end
      end
      DECODE: begin
`ifdef DBG_ECHO_EN
        shreg_nxt = {code, aligned};
        cnt_nxt   = {1'b0, bus.dec_size} + 3'd1;
`else
        shreg_nxt = aligned;
        cnt_nxt   = bus.dec_size;
`endif
        state_nxt = LOAD;
      end
      LOAD: begin
        if (!bus.tx_busy) begin
          bus.tx_start = 1'b1;
          shreg_nxt    = shreg << 8;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt   = cnt - CNT_W'(1);
          state_nxt = LOAD;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // A byte arriving while not IDLE (including the HOLD->IDLE cycle) is lost.
    if (bus.rx_valid && (state != IDLE)) overrun_nxt = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      code      <= 8'h00;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      shreg     <= shreg_nxt;
      cnt       <= cnt_nxt;
      code      <= code_nxt;
      busy_q    <= (state_nxt != IDLE);
      overrun_q <= overrun_nxt;
    end
  end

  assign bus.dec_code = code;
  assign bus.tx_data  = shreg[SH_W-1 -: 8];
  assign bus.busy     = busy_q;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_debug_cmd_sequencer.sv
// Bench for debug_cmd_sequencer: reset checks, a directed vector table,
// randomized commands against a byte-list model, and overrun/reset sequences.
module tb_debug_cmd_sequencer;
  logic clk = 1'b0;
  logic reset;

  debug_cmd_sequencer_if bus();

  debug_cmd_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int t0 = 0;
  int busy_cnt = 0;
  int busy_len = 0;
  int busy_left = 0;
  bit start_prev = 1'b0;
  logic [7:0] got_q[$];
  int         at_q[$];
  logic [7:0] exp_q[$];

  typedef struct {
    logic [7:0]  code;
    int          blen;
    int          n;
    logic [39:0] b;     // expected bytes, first byte in [39:32]
    int          gap;
  } vec_t;
  vec_t tbl[4];

  // Decoder stand-in: a few fixed codes, everything else derived from the code.
  function automatic logic [33:0] dec_model(input logic [7:0] c);
    case (c)
`ifdef DBG_ECHO_EN
      8'h3F: return {32'h0000007E, 2'd0};
`else
      8'h3F: return {32'hDEADBEEF, 2'd3};
`endif
      8'h38: return {32'h000000A5, 2'd0};
      8'h12: return {32'h00001234, 2'd1};
      default: return {c, ~c, c ^ 8'h5A, c + 8'd1, c[1:0]};
    endcase
  endfunction

  always_comb {bus.dec_result, bus.dec_size} = dec_model(bus.dec_code);

  // Expected transmit sequence: optional echo, then result bytes size..0.
  function automatic void build_exp(input logic [7:0] c);
    logic [33:0] d;
    d = dec_model(c);
    exp_q.delete();
`ifdef DBG_ECHO_EN
    exp_q.push_back(c);
`endif
    for (int i = int'(d[1:0]); i >= 0; i--) exp_q.push_back(d[2 + 8*i +: 8]);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Transmitter model and output monitor; runs at negedge+1 / +2.
  initial begin
    bus.tx_busy = 1'b0;
    forever begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      #1;
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) bus.tx_busy = 1'b0;
      end
      if (start_prev && busy_len > 0) begin
        bus.tx_busy = 1'b1;
        busy_left   = busy_len;
      end
      start_prev = 1'b0;
      #1;
      if (bus.tx_start === 1'b1) begin
        got_q.push_back(bus.tx_data);
        at_q.push_back(cyc - t0);
        start_prev = 1'b1;
      end
      if (bus.busy === 1'b1) busy_cnt++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic send(input logic [7:0] c);
    step();
    got_q.delete();
    at_q.delete();
    busy_cnt     = 0;
    t0           = cyc;
    bus.rx_data  = c;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    chk("dec_code_cycle1", bus.dec_code, c);
  endtask

  task automatic wait_idle(input int limit);
    int k = 0;
    while ((bus.busy === 1'b1 || bus.tx_busy === 1'b1) && k < limit) begin
      step();
      k++;
    end
    chk("idle_timeout", {bus.busy, bus.tx_busy}, 2'b00);
  endtask

  task automatic check_resp(input string tag, input int gap);
    int n;
    n = exp_q.size();
    chk({tag, "_count"}, got_q.size(), n);
    for (int j = 0; j < n && j < got_q.size(); j++) chk({tag, "_byte"}, got_q[j], exp_q[j]);
    if (at_q.size() > 0) chk({tag, "_first_start"}, at_q[0], 2);
    for (int j = 1; j < at_q.size(); j++) chk({tag, "_gap"}, at_q[j] - at_q[j-1], gap);
    chk({tag, "_busy_cycles"}, busy_cnt, 1 + 2*n + (gap - 2)*(n - 1));
  endtask

  task automatic do_reset();
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
`ifdef DBG_ECHO_EN
    tbl[0] = '{8'h3F, 0,  2, {8'h3F, 8'h7E, 24'h0}, 2};
    tbl[1] = '{8'h38, 0,  2, {8'h38, 8'hA5, 24'h0}, 2};
    tbl[2] = '{8'h12, 10, 3, {8'h12, 8'h12, 8'h34, 16'h0}, 11};
    tbl[3] = '{8'h38, 3,  2, {8'h38, 8'hA5, 24'h0}, 4};
`else
    tbl[0] = '{8'h3F, 0,  4, 40'hDEADBEEF00, 2};
    tbl[1] = '{8'h38, 0,  1, {8'hA5, 32'h0}, 2};
    tbl[2] = '{8'h12, 10, 2, {8'h12, 8'h34, 24'h0}, 11};
    tbl[3] = '{8'h3F, 3,  4, 40'hDEADBEEF00, 4};
`endif
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h3F;
    t0           = 0;

    // Reset held with rx_valid toggling: outputs stay at reset values.
    for (int i = 0; i < 3; i++) begin
      step();
      bus.rx_valid = ~bus.rx_valid;
      #1;
      chk("rst_dec_code", bus.dec_code, 8'h00);
      chk("rst_tx_data", bus.tx_data, 8'h00);
      chk("rst_tx_start", bus.tx_start, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_overrun", bus.overrun, 1'b0);
    end
    bus.rx_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("rst_no_tx_start", got_q.size(), 0);
    chk("rst_idle_busy", bus.busy, 1'b0);

    // Directed table.
    for (int i = 0; i < 4; i++) begin
      busy_len = tbl[i].blen;
      send(tbl[i].code);
      wait_idle(400);
      exp_q.delete();
      for (int j = 0; j < tbl[i].n; j++) exp_q.push_back(tbl[i].b[39 - 8*j -: 8]);
      check_resp("table", tbl[i].gap);
      chk("table_code_hold", bus.dec_code, tbl[i].code);
    end

    // Random commands and transmitter busy lengths against the model.
    for (int i = 0; i < 40; i++) begin
      logic [7:0] c;
      c        = 8'($urandom);
      busy_len = int'($urandom_range(0, 3));
      send(c);
      wait_idle(400);
      build_exp(c);
      check_resp("rand", (busy_len < 2) ? 2 : busy_len + 1);
    end
    busy_len = 0;
    chk("no_overrun_yet", bus.overrun, 1'b0);

    // Second byte arriving during LOAD is dropped and flagged.
    send(8'h3F);
    step();
    bus.rx_data  = 8'h01;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    chk("ovr_flag", bus.overrun, 1'b1);
    chk("ovr_dec_code", bus.dec_code, 8'h3F);
    wait_idle(400);
    build_exp(8'h3F);
    check_resp("ovr", 2);
    chk("ovr_sticky", bus.overrun, 1'b1);

    // Byte arriving in the final HOLD cycle is also dropped.
    do_reset();
    chk("hold_ovr_cleared", bus.overrun, 1'b0);
    send(8'h38);
    step();
    step();
    bus.rx_data  = 8'h12;
    bus.rx_valid = 1'b1;
    step();
    bus.rx_valid = 1'b0;
    chk("hold_ovr_flag", bus.overrun, 1'b1);
    chk("hold_dec_code", bus.dec_code, 8'h38);
    wait_idle(400);
    repeat (5) step();
    build_exp(8'h38);
    check_resp("hold", 2);
    chk("hold_still_idle", bus.busy, 1'b0);

    // Reset after the second byte of a long response.
    do_reset();
    send(8'hF3);
    repeat (4) step();
    reset = 1'b1;
    #1;
    chk("mid_tx_start", bus.tx_start, 1'b0);
    chk("mid_busy", bus.busy, 1'b0);
    chk("mid_dec_code", bus.dec_code, 8'h00);
    chk("mid_tx_data", bus.tx_data, 8'h00);
    chk("mid_overrun", bus.overrun, 1'b0);
    step();
    step();
    reset = 1'b0;
    repeat (10) step();
    build_exp(8'hF3);
    chk("mid_start_count", got_q.size(), 2);
    if (got_q.size() >= 2) begin
      chk("mid_byte0", got_q[0], exp_q[0]);
      chk("mid_byte1", got_q[1], exp_q[1]);
    end
    chk("mid_busy_after", bus.busy, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
